// File: rtl/pipelined_addsub_cla_pkg.sv
// rtl/pipelined_addsub_cla_pkg.sv - shared encodings and pipeline-depth helper for the add/sub pipeline
//
// Purpose : mode encodings carried with each beat, and the stage-count
//           derivation used by the top level to size its pipeline.
// Ports   : none (package).

package pipelined_addsub_cla_pkg;

    typedef enum logic {
        MODE_ADD = 1'b0,
        MODE_SUB = 1'b1
    } mode_e;

    // One pipeline stage per lookahead group.
    function automatic int calc_nstage(input int width, input int group);
        return width / group;
    endfunction

endpackage

// File: rtl/pipelined_addsub_cla_cla_group.sv
// rtl/pipelined_addsub_cla_cla_group.sv - one GROUP-bit carry-lookahead adder slice
//
// Purpose : full carry lookahead across a GROUP-bit slice; every internal
//           carry is a flat sum-of-products of generate/propagate terms and
//           the slice carry-in, so no carry ripples inside the group.
// Ports   : a_i, b_i  - slice operands (b already conditioned for subtract)
//           cin_i     - carry into bit 0 of the slice
//           sum_o     - slice sum
//           cout_o    - carry out of the slice MSB
//           c_msb_o   - carry into the slice MSB (used for signed overflow)

module cla_group #(
    parameter int GROUP = 4
) (
    input  logic [GROUP-1:0] a_i,
    input  logic [GROUP-1:0] b_i,
    input  logic             cin_i,
    output logic [GROUP-1:0] sum_o,
    output logic             cout_o,
    output logic             c_msb_o
);

    logic [GROUP-1:0] g;
    logic [GROUP-1:0] p;
    logic [GROUP:0]   c;

    assign g = a_i & b_i;
    assign p = a_i ^ b_i;

    // c[i+1] = g[i] | p[i]g[i-1] | ... | p[i..0]cin, expanded term by term.
    always_comb begin
        logic term;
        logic acc;
        c    = '0;
        c[0] = cin_i;
        for (int i = 0; i < GROUP; i++) begin
            term = cin_i;
            for (int j = 0; j <= i; j++) begin
                term = term & p[j];
            end
            acc = term;
            for (int j = 0; j <= i; j++) begin
                term = g[j];
                for (int m = j + 1; m <= i; m++) begin
                    term = term & p[m];
                end
                acc = acc | term;
            end
            c[i+1] = acc;
        end
    end

    assign sum_o   = p ^ c[GROUP-1:0];
    assign cout_o  = c[GROUP];
    assign c_msb_o = c[GROUP-1];

endmodule

// File: rtl/pipelined_addsub_cla.sv
// rtl/pipelined_addsub_cla.sv - skewed pipelined adder/subtractor, one lookahead group per stage
//
// Purpose : a +/- b over NSTAGE = WIDTH/GROUP stages. Stage k resolves bits
//           [k*GROUP +: GROUP] using the carry registered by stage k-1;
//           untouched operand slices and finished sum slices travel along
//           in the stage registers. Subtract is a + ~b + 1 with the +1
//           entering as the stage-0 carry-in.
// Ports   : clk, rst_n          - clock, synchronous active-low reset
//           in_valid/in_ready   - operand handshake (a, b, mode)
//           out_valid/out_ready - result handshake (sum, cout, overflow, zero)
//           The whole pipeline advances together whenever in_ready is high.

module pipelined_addsub_cla
    import pipelined_addsub_cla_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int GROUP = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow,
    output logic             zero
);

    localparam int NSTAGE = calc_nstage(WIDTH, GROUP);

    logic advance;

    // Per-stage registers; index k holds the beat after group k is resolved.
    logic [NSTAGE-1:0]            vld_q;
    logic [NSTAGE-1:0]            cy_q;
    logic [NSTAGE-1:0][WIDTH-1:0] s_q;
    // Operands are only needed by later stages, so the last stage has none.
    logic [NSTAGE-2:0][WIDTH-1:0] a_q;
    logic [NSTAGE-2:0][WIDTH-1:0] b_q;
    logic [NSTAGE-2:0]            mode_q;
    logic                         ovf_q;
    logic                         zero_q;

    logic [NSTAGE-1:0]            cy_d;
    logic [NSTAGE-1:0]            msb_c;
    logic [NSTAGE-1:0][WIDTH-1:0] s_d;
    logic [NSTAGE-1:0][GROUP-1:0] grp_a;
    logic [NSTAGE-1:0][GROUP-1:0] grp_b;
    logic [NSTAGE-1:0][GROUP-1:0] grp_sum;
    logic [NSTAGE-1:0]            grp_cin;
    logic                         ovf_d;
    logic                         zero_d;

    assign in_ready = !out_valid || out_ready;
    assign advance  = in_ready;

    for (genvar k = 0; k < NSTAGE; k++) begin : g_stage
        if (k == 0) begin : g_first
            assign grp_a[k]   = a[0 +: GROUP];
            assign grp_b[k]   = b[0 +: GROUP] ^ {GROUP{mode == MODE_SUB}};
            assign grp_cin[k] = (mode == MODE_SUB);
            assign s_d[k]     = WIDTH'(grp_sum[k]);
        end else begin : g_rest
            assign grp_a[k]   = a_q[k-1][k*GROUP +: GROUP];
            assign grp_b[k]   = b_q[k-1][k*GROUP +: GROUP] ^ {GROUP{mode_q[k-1] == MODE_SUB}};
            assign grp_cin[k] = cy_q[k-1];
            // Upper slices of s_q are still zero, so OR merges the new slice.
            assign s_d[k]     = s_q[k-1] | (WIDTH'(grp_sum[k]) << (k * GROUP));
        end

        cla_group #(
            .GROUP (GROUP)
        ) u_cla (
            .a_i     (grp_a[k]),
            .b_i     (grp_b[k]),
            .cin_i   (grp_cin[k]),
            .sum_o   (grp_sum[k]),
            .cout_o  (cy_d[k]),
            .c_msb_o (msb_c[k])
        );
    end

    assign ovf_d  = msb_c[NSTAGE-1] ^ cy_d[NSTAGE-1];
    assign zero_d = (s_d[NSTAGE-1] == '0);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_q  <= '0;
            cy_q   <= '0;
            s_q    <= '0;
            a_q    <= '0;
            b_q    <= '0;
            mode_q <= '0;
            ovf_q  <= 1'b0;
            zero_q <= 1'b0;
        end else if (advance) begin
            // Bubbles shift through as cleared valid bits.
            vld_q     <= {vld_q[NSTAGE-2:0], in_valid};
            cy_q      <= cy_d;
            s_q       <= s_d;
            a_q[0]    <= a;
            b_q[0]    <= b;
            mode_q[0] <= mode;
            for (int k = 1; k < NSTAGE - 1; k++) begin
                a_q[k]    <= a_q[k-1];
                b_q[k]    <= b_q[k-1];
                mode_q[k] <= mode_q[k-1];
            end
            ovf_q  <= ovf_d;
            zero_q <= zero_d;
        end
    end

    assign out_valid = vld_q[NSTAGE-1];
    assign sum       = s_q[NSTAGE-1];
    assign cout      = cy_q[NSTAGE-1];
    assign overflow  = ovf_q;
    assign zero      = zero_q;

endmodule

// File: tb/tb_pipelined_addsub_cla.sv
// tb/tb_pipelined_addsub_cla.sv - directed self-checking bench for pipelined_addsub_cla

module tb_pipelined_addsub_cla;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        mode;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] sum;
    logic        cout;
    logic        overflow;
    logic        zero;

    int vectors;
    int miscompares;

    pipelined_addsub_cla #(
        .WIDTH (16),
        .GROUP (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .mode      (mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .overflow  (overflow),
        .zero      (zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Independent reference: {zero, overflow, cout, sum}.
    function automatic logic [18:0] model(input logic [15:0] ta, input logic [15:0] tb, input logic tm);
        logic [16:0] full;
        logic        v;
        if (tm) full = {1'b0, ta} - {1'b0, tb};
        else    full = {1'b0, ta} + {1'b0, tb};
        // Subtract: carry out is "no borrow", i.e. inverse of the borrow bit.
        if (tm) begin
            full[16] = ~full[16];
            v = (ta[15] != tb[15]) && (full[15] != ta[15]);
        end else begin
            v = (ta[15] == tb[15]) && (full[15] != ta[15]);
        end
        return {(full[15:0] == 16'h0), v, full[16], full[15:0]};
    endfunction

    task automatic run_one(input string tag, input logic [15:0] ta, input logic [15:0] tb, input logic tm,
                           input logic [15:0] es, input logic ec, input logic ev, input logic ez);
        int lat;
        in_valid = 1'b1;
        a = ta;
        b = tb;
        mode = tm;
        step();
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 10) begin
            step();
            lat++;
        end
        chk({tag, " latency"}, lat, 4);
        chk({tag, " sum"}, sum, es);
        chk({tag, " cout"}, cout, ec);
        chk({tag, " overflow"}, overflow, ev);
        chk({tag, " zero"}, zero, ez);
        step();
    endtask

    initial begin
        logic [15:0] ra [8];
        logic [15:0] rb [8];
        logic        rm [8];
        logic [18:0] expq [$];
        logic [18:0] held;
        logic [18:0] front;
        logic        was_stalled;
        logic        acc_in;
        logic        acc_out;
        int          sent;
        int          got;
        int          cyc;

        vectors = 0;
        miscompares = 0;
        rst_n = 1'b0;
        in_valid = 1'b0;
        a = '0;
        b = '0;
        mode = 1'b0;
        out_ready = 1'b1;

        step();
        step();
        chk("reset out_valid", out_valid, 0);
        chk("reset sum", sum, 0);
        chk("reset cout", cout, 0);
        chk("reset overflow", overflow, 0);
        chk("reset zero", zero, 0);
        rst_n = 1'b1;
        #1;
        chk("reset in_ready", in_ready, 1);

        run_one("add 0+1",       16'h0000, 16'h0001, 1'b0, 16'h0001, 1'b0, 1'b0, 1'b0);
        run_one("sub F-1",       16'h000F, 16'h0001, 1'b1, 16'h000E, 1'b1, 1'b0, 1'b0);
        run_one("sub 0-1",       16'h0000, 16'h0001, 1'b1, 16'hFFFF, 1'b0, 1'b0, 1'b0);
        run_one("add 7FFF+1",    16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0);
        run_one("sub 8000-1",    16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0);
        run_one("add FFFF+1",    16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
        run_one("sub equal",     16'h1234, 16'h1234, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1);
        run_one("add 8000+8000", 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1);
        run_one("add 0FFF+1",    16'h0FFF, 16'h0001, 1'b0, 16'h1000, 1'b0, 1'b0, 1'b0);
        run_one("sub 1000-1",    16'h1000, 16'h0001, 1'b1, 16'h0FFF, 1'b1, 1'b0, 1'b0);

        // Back-to-back random beats against a pseudo-random out_ready.
        for (int i = 0; i < 8; i++) begin
            ra[i] = 16'($urandom);
            rb[i] = 16'($urandom);
            rm[i] = 1'($urandom);
        end
        sent = 0;
        got = 0;
        cyc = 0;
        was_stalled = 1'b0;
        held = '0;
        while (got < 8 && cyc < 300) begin
            in_valid = (sent < 8);
            if (sent < 8) begin
                a = ra[sent];
                b = rb[sent];
                mode = rm[sent];
            end
            out_ready = 1'($urandom);
            #1;
            if (was_stalled) begin
                chk("stall valid held", out_valid, 1);
                chk("stall data held", {zero, overflow, cout, sum}, held);
            end
            acc_in  = in_valid && in_ready;
            acc_out = out_valid && out_ready;
            if (acc_out) begin
                if (expq.size() > 0) begin
                    front = expq.pop_front();
                    chk($sformatf("stream beat %0d", got), {zero, overflow, cout, sum}, front);
                end else begin
                    chk("stream unexpected beat", 1, 0);
                end
                got++;
            end
            was_stalled = out_valid && !out_ready;
            held = {zero, overflow, cout, sum};
            if (acc_in) begin
                expq.push_back(model(ra[sent], rb[sent], rm[sent]));
                sent++;
            end
            step();
            cyc++;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        chk("stream beats received", got, 8);
        chk("stream queue drained", expq.size(), 0);

        // Reset with three beats in flight.
        step();
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            a = 16'h1111 * 16'(i + 1);
            b = 16'h0101;
            mode = 1'b0;
            step();
        end
        in_valid = 1'b0;
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk("midreset out_valid", out_valid, 0);
        chk("midreset in_ready", in_ready, 1);
        for (int i = 0; i < 8; i++) begin
            step();
            chk($sformatf("post-reset no stale %0d", i), out_valid, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/pipelined_addsub_cla.md
PIPELINED_ADDSUB_CLA -- requirements
Module: pipelined_addsub_cla

Interface
REQ-001 SHALL provide parameter WIDTH, default 16, meaning operand/result width in bits.
REQ-002 SHALL provide parameter GROUP, default 4, meaning lookahead group width; WIDTH SHALL be a multiple of GROUP.
REQ-003 SHALL derive NSTAGE = WIDTH/GROUP as pipeline depth.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst_n  input  1  reset, synchronous, active-low.
REQ-006 in_valid  input  1  operand beat offered.
REQ-007 in_ready  output  1  operand beat accepted this cycle when high with in_valid.
REQ-008 a  input  WIDTH  first operand.
REQ-009 b  input  WIDTH  second operand.
REQ-010 mode  input  1  0 = a+b, 1 = a-b.
REQ-011 out_valid  output  1  result beat presented.
REQ-012 out_ready  input  1  downstream accepts result.
REQ-013 sum  output  WIDTH  result.
REQ-014 cout  output  1  carry out of MSB (subtract: 1 = no borrow).
REQ-015 overflow  output  1  two's-complement signed overflow.
REQ-016 zero  output  1  high when sum is all zeros.

Function
REQ-017 Subtract SHALL be computed as a + ~b + 1; mode SHALL be captured with the operands and travel with the beat.
REQ-018 Stage k (0..NSTAGE-1) SHALL compute bits [k*GROUP +: GROUP] with full carry lookahead inside the group, using the registered carry from stage k-1 (stage 0 carry-in = mode).
REQ-019 Unprocessed operand slices and finished sum slices SHALL be carried forward in pipeline registers (skewed datapath).
REQ-020 Latency SHALL be exactly NSTAGE cycles from accepting handshake to out_valid, with no stall.
REQ-021 Throughput SHALL be one beat per cycle when out_ready is held high.
REQ-022 overflow SHALL equal carry into MSB XOR carry out of MSB; cout SHALL be carry out of MSB.
REQ-023 in_ready SHALL equal (!out_valid || out_ready); whole pipeline advances only when in_ready is high.
REQ-024 During a stall every stage register, including valid bits, SHALL hold; sum/cout/overflow/zero SHALL remain stable while out_valid && !out_ready.
REQ-025 Beats SHALL leave in acceptance order with no loss or duplication; bubbles (in_valid low) SHALL propagate as invalid stages.
REQ-026 Simultaneous output acceptance and input acceptance in one cycle SHALL be legal and lose nothing.
REQ-027 Arithmetic SHALL wrap modulo 2^WIDTH.

Reset
REQ-028 When rst_n is low at a clock edge, all stage valid bits, out_valid, sum, cout, overflow SHALL clear to 0, and zero SHALL clear to 0.
REQ-029 Reset mid-operation SHALL discard all in-flight beats; no pre-reset beat SHALL appear after reset release.
REQ-030 in_ready SHALL be 1 in the first cycle after reset release.

Structure
REQ-031 A shared package SHALL hold the mode encodings (MODE_ADD=0, MODE_SUB=1) and the NSTAGE derivation function.
REQ-032 One sub-module cla_group SHALL implement a GROUP-bit lookahead slice (bit generate/propagate, group carries, carry-out); pipelined_addsub_cla SHALL instantiate NSTAGE copies.

Verification (WIDTH=16, GROUP=4)
REQ-033 mode0, 0x0000+0x0001 -> sum 0x0001, cout 0, overflow 0, zero 0, out_valid exactly 4 cycles after acceptance.
REQ-034 mode1, 0x000F-0x0001 -> 0x000E, cout 1; mode1, 0x0000-0x0001 -> 0xFFFF, cout 0, overflow 0.
REQ-035 mode0, 0x7FFF+0x0001 -> 0x8000, overflow 1, cout 0; mode1, 0x8000-0x0001 -> 0x7FFF, overflow 1, cout 1; mode0, 0xFFFF+0x0001 -> 0x0000, cout 1, zero 1.
REQ-036 8 back-to-back random beats, out_ready toggled pseudo-randomly -> all 8 results correct, in order, outputs stable during stalls.
REQ-037 rst_n low for 1 cycle with 3 beats in flight -> out_valid 0 next cycle, no stale beat emitted afterwards, in_ready 1.
